memory_access_stage: RTL
========================

Name: memory_access_stage

Overview:
- Memory stage of the 5-stage RISC-V pipeline, directly downstream of the EX->MEM pipeline register.
- Consumes the M-stage bundle and performs loads and stores on a data-memory request/acknowledge bus with variable latency.
- Aligns byte/half/word store data and builds byte enables; sign- or zero-extends load data according to DextControlM.
- Stalls the pipeline while the bus is busy, flags misaligned accesses, and registers the MEM->WB bundle.

Parameters:
DATA_W, 32, data/bus width (fixed at 32 for RV32; other values unsupported)
ADDR_W, 32, address width driven on dmem_addr

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
MemReadM  in  1  load in M stage
MemWriteM  in  1  store in M stage
RegWriteM  in  1  instruction writes rd
ResultSrcM  in  2  writeback mux select, passed through
DextControlM  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
RdM  in  5  destination register
ALUResultM  in  32  effective address / ALU result
WriteDataM  in  32  store source (rs2)
PCPlus4M  in  32  passed through
ImmExtM  in  32  passed through
dmem_req  out  1  bus request
dmem_we  out  1  1 = write
dmem_addr  out  ADDR_W  word address: ALUResultM with [1:0] forced to 00
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle
dmem_rdata  in  32  read word
StallM  out  1  to hazard unit: freeze F/D/E/M
RegWriteW, ResultSrcW, RdW  out  1/2/5  registered WB controls
ALUResultW, ReadDataW, PCPlus4W, ImmExtW  out  32 each  registered WB data
MisalignW  out  1  registered misaligned-access flag

Behaviour:
- Access request: acc = MemReadM | MemWriteM.
- Misalignment (mis):
  - H/HU: addr[0] != 0.
  - W: addr[1:0] != 00.
  - B/BU: never misaligned.
- Store lanes:
  - SB: wdata = {4{WriteDataM[7:0]}}, be = 0001 << addr[1:0].
  - SH: wdata = {2{WriteDataM[15:0]}}, be = 0011 << (2*addr[1]).
  - SW: wdata = WriteDataM, be = 1111.
  - For loads, be = 1111.
- Load extraction: select byte addr[1:0] or half addr[1] from dmem_rdata. B/H sign-extend; BU/HU zero-extend; W passes the word.
- FSM states: IDLE, WAIT.
- IDLE:
  - acc & !mis: dmem_req = 1 combinationally, driving the current M-stage address, data, be and we. Request fields are latched into internal registers on the same edge.
  - If dmem_ack is high in that cycle: zero-wait completion, StallM = 0, stay in IDLE.
  - If dmem_ack is low: StallM = 1, go to WAIT.
- WAIT:
  - dmem_req = 1, driven from the latched fields; StallM = 1.
  - On dmem_ack: StallM = 0, return to IDLE.
  - The bus must not change address or data while in WAIT.
- Misaligned access: no bus request and no stall. The W register captures MisalignW = 1, with RegWriteW = 0 and RdW = 0.
- Non-memory instruction: no request, no stall, and the bundle passes through to the W register.
- W register update, every edge:
  - When StallM = 1, load a bubble: RegWriteW = 0, RdW = 0, MisalignW = 0, all other W outputs 0.
  - Otherwise capture the M-stage values. ReadDataW takes the extended load data on a completing load and 0 otherwise.
- Latency:
  - Memory instruction reaches W one edge after the dmem_ack cycle.
  - Non-memory instruction reaches W one edge after entering M.
- dmem_ack while in IDLE with no request: ignored.
- Reset, including mid-WAIT: on the edge where reset = 1, FSM -> IDLE, all W outputs and latched fields -> 0. dmem_req and StallM fall once in IDLE with reset held. A late dmem_ack after reset is ignored.
- Upstream must hold the M-stage inputs while StallM = 1; the block does not depend on this, because it uses its latched fields.

Test Plan:
- LW addr 0x100, dmem_ack same cycle, rdata 0xDEADBEEF -> StallM never high; next edge RegWriteW = 1, ReadDataW = 0xDEADBEEF.
- LB addr 0x103, rdata 0x80FF0000, ack after 3 wait cycles -> StallM high 3 cycles, dmem_addr 0x100 stable throughout; ReadDataW = 0xFFFFFF80. Repeat as LBU -> ReadDataW = 0x00000080.
- SH addr 0x206, WriteDataM 0x1234ABCD -> dmem_we = 1, dmem_be = 1100, dmem_wdata = 0xABCDABCD, dmem_addr = 0x204.
- LW addr 0x102 -> dmem_req stays 0, StallM stays 0; next edge MisalignW = 1, RegWriteW = 0.
- Reset asserted during the 2nd WAIT cycle, ack arrives 1 cycle after reset deasserts -> FSM IDLE, dmem_req = 0, all W outputs 0, ack ignored.
- ADD (no memory access), ALUResultM 0x55 followed by SW -> ALUResultW = 0x55 next edge; during the SW wait cycles RegWriteW = 0 (bubble).

Source files
------------

// File: rtl/memory_access_stage.sv
// RV32 memory stage: drives the data-memory request/ack bus, aligns store lanes,
// extends load data, stalls while the bus is busy and registers the MEM->WB bundle.
module memory_access_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic              RegWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic [2:0]        DextControlM,
    input  logic [4:0]        RdM,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [DATA_W-1:0] PCPlus4M,
    input  logic [DATA_W-1:0] ImmExtM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              StallM,
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcW,
    output logic [4:0]        RdW,
    output logic [DATA_W-1:0] ALUResultW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] PCPlus4W,
    output logic [DATA_W-1:0] ImmExtW,
    output logic              MisalignW
);

    // state | meaning
    // IDLE  | no access outstanding; a new aligned access is issued straight from M inputs
    // WAIT  | access issued, bus driven from latched fields until dmem_ack
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state;

    logic              lat_read, lat_we, lat_rw;
    logic [1:0]        lat_rs;
    logic [2:0]        lat_dext;
    logic [4:0]        lat_rd;
    logic [3:0]        lat_be;
    logic [DATA_W-1:0] lat_alu, lat_wdata, lat_pc4, lat_imm;

    logic              acc, mis, go, in_wait, done;
    logic [3:0]        st_be;
    logic [DATA_W-1:0] st_wdata;
    logic              cur_read, cur_rw;
    logic [1:0]        cur_rs;
    logic [2:0]        cur_dext;
    logic [4:0]        cur_rd;
    logic [DATA_W-1:0] cur_alu, cur_pc4, cur_imm;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] load_v;

    always_comb begin
        acc = MemReadM | MemWriteM;
        case (DextControlM[1:0])
            2'b01:   mis = ALUResultM[0];
            2'b10:   mis = |ALUResultM[1:0];
            default: mis = 1'b0;
        endcase
        go = acc & ~mis;

        st_wdata = WriteDataM;
        st_be    = 4'b1111;
        if (MemWriteM) begin
            case (DextControlM[1:0])
                2'b00: begin
                    st_wdata = {4{WriteDataM[7:0]}};
                    st_be    = 4'b0001 << ALUResultM[1:0];
                end
                2'b01: begin
                    st_wdata = {2{WriteDataM[15:0]}};
                    st_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    st_wdata = WriteDataM;
                    st_be    = 4'b1111;
                end
            endcase
        end
    end

    // In WAIT everything comes from the latched copy so the bus stays frozen
    // even if upstream lets the M-stage inputs drift.
    always_comb begin
        in_wait  = (state == WAIT);
        cur_read = in_wait ? lat_read : MemReadM;
        cur_rw   = in_wait ? lat_rw   : RegWriteM;
        cur_rs   = in_wait ? lat_rs   : ResultSrcM;
        cur_dext = in_wait ? lat_dext : DextControlM;
        cur_rd   = in_wait ? lat_rd   : RdM;
        cur_alu  = in_wait ? lat_alu  : ALUResultM;
        cur_pc4  = in_wait ? lat_pc4  : PCPlus4M;
        cur_imm  = in_wait ? lat_imm  : ImmExtM;

        dmem_req   = ~reset & (in_wait | go);
        dmem_we    = in_wait ? lat_we    : MemWriteM;
        dmem_wdata = in_wait ? lat_wdata : st_wdata;
        dmem_be    = in_wait ? lat_be    : st_be;
        dmem_addr  = {cur_alu[ADDR_W-1:2], 2'b00};
        StallM     = dmem_req & ~dmem_ack;
        done       = dmem_req & dmem_ack;

        byte_v = 8'(dmem_rdata >> {cur_alu[1:0], 3'b000});
        half_v = 16'(dmem_rdata >> {cur_alu[1], 4'b0000});
        case (cur_dext)
            3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_v = {{16{half_v[15]}}, half_v};
            3'b100:  load_v = {24'b0, byte_v};
            3'b101:  load_v = {16'b0, half_v};
            default: load_v = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lat_read   <= 1'b0;
            lat_we     <= 1'b0;
            lat_rw     <= 1'b0;
            lat_rs     <= '0;
            lat_dext   <= '0;
            lat_rd     <= '0;
            lat_be     <= '0;
            lat_alu    <= '0;
            lat_wdata  <= '0;
            lat_pc4    <= '0;
            lat_imm    <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            RdW        <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            ImmExtW    <= '0;
            MisalignW  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                lat_read  <= MemReadM;
                lat_we    <= MemWriteM;
                lat_rw    <= RegWriteM;
                lat_rs    <= ResultSrcM;
                lat_dext  <= DextControlM;
                lat_rd    <= RdM;
                lat_be    <= st_be;
                lat_alu   <= ALUResultM;
                lat_wdata <= st_wdata;
                lat_pc4   <= PCPlus4M;
                lat_imm   <= ImmExtM;
            end
            state <= StallM ? WAIT : IDLE;

            if (StallM) begin
                RegWriteW  <= 1'b0;
                ResultSrcW <= '0;
                RdW        <= '0;
                ALUResultW <= '0;
                ReadDataW  <= '0;
                PCPlus4W   <= '0;
                ImmExtW    <= '0;
                MisalignW  <= 1'b0;
            end else begin
                MisalignW  <= ~in_wait & acc & mis;
                RegWriteW  <= cur_rw & ~(~in_wait & acc & mis);
                RdW        <= (~in_wait & acc & mis) ? 5'd0 : cur_rd;
                ResultSrcW <= cur_rs;
                ALUResultW <= cur_alu;
                PCPlus4W   <= cur_pc4;
                ImmExtW    <= cur_imm;
                ReadDataW  <= (done & cur_read) ? load_v : '0;
            end
        end
    end

endmodule
